// File: rtl/fwft_fifo.sv
// -----------------------------------------------------------------------------
// fwft_fifo
//   Single-clock first-word-fall-through FIFO. The oldest stored word is
//   always presented on dout while empty is low, so a consumer can use dout
//   in the same cycle it asserts rd_en.
//
//   Pointers carry one extra wrap bit above the storage address. Equal
//   pointers mean empty. Equal addresses with differing wrap bits mean full.
//   full, empty and level are decoded from registered pointers only.
//
// Parameters
//   FIFO_DATA_WIDTH  : bits per stored word (default 24)
//   FIFO_BUFFER_SIZE : depth in words, power of two in 4..1024 (default 16)
//
// Ports
//   clock  : rising-edge clock for all state
//   reset  : synchronous active-high reset; clears both pointers
//   wr_en  : write request; accepted only when full is low
//   din    : write data, sampled together with wr_en
//   full   : FIFO holds FIFO_BUFFER_SIZE words
//   rd_en  : read/pop request; accepted only when empty is low
//   dout   : head-of-queue word, valid while empty is low
//   empty  : FIFO holds no words
//   level  : (only with FIFO_LEVEL_EN) occupancy, write ptr minus read ptr
//
// Build option
//   FIFO_LEVEL_EN : define to add the level output port.
// -----------------------------------------------------------------------------
module fwft_fifo #(
  parameter int unsigned FIFO_DATA_WIDTH  = 24,
  parameter int unsigned FIFO_BUFFER_SIZE = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0]         din,
  output logic                               full,
  input  logic                               rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]         dout,
  output logic                               empty
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(FIFO_BUFFER_SIZE):0]  level
`endif
);

  localparam int unsigned AW = $clog2(FIFO_BUFFER_SIZE);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [FIFO_DATA_WIDTH-1:0] r_mem [0:FIFO_BUFFER_SIZE-1];

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_rd_accept;

  // Status decode from registered pointers only.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
              (r_wr_ptr[AW]     != r_rd_ptr[AW]);
  end

  // A request against the blocking condition is dropped; the other side of a
  // simultaneous request still proceeds.
  always_comb begin
    w_wr_accept = wr_en && !w_full;
    w_rd_accept = rd_en && !w_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage has no reset so it can map to distributed RAM; a reset cycle
  // still blocks the write so old contents simply become unreachable.
  always_ff @(posedge clock) begin
    if (!reset && w_wr_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_comb begin
    full  = w_full;
    empty = w_empty;
    dout  = r_mem[r_rd_ptr[AW-1:0]];
  end

`ifdef FIFO_LEVEL_EN
  always_comb begin
    level = r_wr_ptr - r_rd_ptr;
  end
`endif

endmodule

// File: doc/fwft_fifo.md
FWFT_FIFO -- requirements
Module: fwft_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DATA_WIDTH, default 24, giving the width of each stored word in bits.
REQ-002 The block SHALL have parameter FIFO_BUFFER_SIZE, default 16, giving the depth in words; legal values are powers of two from 4 to 1024.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port wr_en, input, 1 bit: write request from the producer.
REQ-006 Port din, input, FIFO_DATA_WIDTH bits: write data, sampled with wr_en.
REQ-007 Port full, output, 1 bit: high when the FIFO holds FIFO_BUFFER_SIZE words.
REQ-008 Port rd_en, input, 1 bit: read/pop request from the consumer.
REQ-009 Port dout, output, FIFO_DATA_WIDTH bits: head-of-queue word, valid whenever empty is low.
REQ-010 Port empty, output, 1 bit: high when the FIFO holds zero words.

Function
REQ-011 The block SHALL be first-word-fall-through: while empty is low, dout SHALL already present the oldest word, so a consumer may use dout in the same cycle it asserts rd_en.
REQ-012 A write SHALL be accepted on a rising edge iff wr_en=1 and full=0; din is stored at the write pointer and the write pointer advances by one.
REQ-013 A read SHALL be accepted on a rising edge iff rd_en=1 and empty=0; the read pointer advances by one and dout moves to the next word.
REQ-014 wr_en while full=1 SHALL be ignored with no state change, even if rd_en=1 in the same cycle; in that cycle only the read is performed.
REQ-015 rd_en while empty=1 SHALL be ignored with no state change, even if wr_en=1 in the same cycle; in that cycle only the write is performed.
REQ-016 When a read and a write are both accepted in one cycle, the occupancy SHALL stay unchanged and both pointers SHALL advance.
REQ-017 Pointers SHALL be $clog2(FIFO_BUFFER_SIZE)+1 bits wide, where the MSB is a wrap bit and the low bits address storage.
REQ-018 Pointers SHALL wrap from FIFO_BUFFER_SIZE-1 to 0 by natural binary overflow of the low bits, toggling the wrap bit.
REQ-019 empty SHALL be 1 iff the read and write pointers are fully equal.
REQ-020 full SHALL be 1 iff the address bits of the read and write pointers are equal and their wrap bits differ.
REQ-021 full and empty SHALL be driven from registered pointers only, with no combinational path from wr_en, rd_en or din.
REQ-022 Write-to-read latency SHALL be one cycle: a word written into an empty FIFO at edge N appears on dout, with empty=0, after edge N.
REQ-023 dout SHALL be a combinational read of storage at the read address; its value while empty=1 is don't-care.
REQ-024 Storage SHALL be a plain register array with no reset, so it is inferable as distributed RAM.

Reset
REQ-025 While reset=1 at a rising edge, both pointers SHALL clear to 0, giving empty=1 and full=0 after that edge.
REQ-026 Reset SHALL take priority over any simultaneous wr_en or rd_en; no write or read occurs in that cycle.
REQ-027 Reset asserted mid-operation SHALL discard all stored words logically; storage contents are left unchanged but are unreachable.

Configuration
REQ-028 When macro FIFO_LEVEL_EN is defined, the block SHALL add output port level, $clog2(FIFO_BUFFER_SIZE)+1 bits, equal to the write pointer minus the read pointer modulo 2^(ptr width).
REQ-029 With FIFO_LEVEL_EN defined, level SHALL be 0 after reset, SHALL be registered-pointer derived, and SHALL update on the same edge as full and empty.
REQ-030 With FIFO_LEVEL_EN undefined, port level and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then idle: empty=1, full=0, and (with FIFO_LEVEL_EN) level=0; rd_en=1 for 3 cycles leaves these unchanged.
REQ-032 Default parameters: write 0x000001..0x000010 (16 words) -> full=1 after the 16th write; a 17th write of 0xFFFFFF is dropped; 16 reads return 0x000001..0x000010 in order, then empty=1.
REQ-033 FWFT latency: write 0xABCDEF into an empty FIFO at edge N -> after edge N, empty=0 and dout=0xABCDEF, with no read having been issued.
REQ-034 Simultaneous events: at level 5, wr_en=rd_en=1 for 40 cycles (pointers wrap twice) -> level stays 5 and data order is preserved; at full, wr_en=rd_en=1 performs the read only, so full drops; at empty, wr_en=rd_en=1 performs the write only, so empty drops.
REQ-035 Reset mid-operation: with 7 words stored, assert reset together with wr_en=1 for one cycle -> empty=1 and full=0 afterwards; the next written word 0x123456 is the first one read.
REQ-036 Randomized producer/consumer traffic against a queue model for 10k cycles with FIFO_BUFFER_SIZE=4 -> no mismatch, no accepted write while full, no accepted read while empty.
